// File: rtl/fir_pkg.sv
// Shared types and constants for the sequential FIR MAC block.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  function automatic int acc_width(int n, int t);
    return 2 * n + $clog2(t);
  endfunction

  function automatic longint sat_hi(int n);
    return (longint'(1) <<< (n - 1)) - 1;
  endfunction

  function automatic longint sat_lo(int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

endpackage

// File: rtl/fir_seq_mac_if.sv
// Sample, result and coefficient-port bundle for fir_seq_mac.
interface fir_seq_mac_if #(
  parameter int NUM_TAPS    = 8,
  parameter int NUMBER_SIZE = 16
);

  logic                          coeff_we;
  logic [$clog2(NUM_TAPS)-1:0]   coeff_addr;
  logic signed [NUMBER_SIZE-1:0] coeff_data;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [NUMBER_SIZE-1:0] in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [NUMBER_SIZE-1:0] out_data;
  logic                          busy;

  modport master (
    output coeff_we, coeff_addr, coeff_data,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  coeff_we, coeff_addr, coeff_data,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with a wide accumulator,
// arithmetic shift and saturation to the sample width.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int NUM_TAPS    = 8,
  parameter int NUMBER_SIZE = 16,
  parameter int SHIFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          clr,
  input  logic                          step,
  input  logic signed [NUMBER_SIZE-1:0] coeff,
  input  logic signed [NUMBER_SIZE-1:0] sample,
  output logic signed [NUMBER_SIZE-1:0] res
);

  localparam int N  = NUMBER_SIZE;
  localparam int AW = acc_width(N, NUM_TAPS);
  localparam logic signed [AW-1:0] HI = AW'(sat_hi(N));
  localparam logic signed [AW-1:0] LO = AW'(sat_lo(N));

  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  sh;

  assign prod = (2*N)'(coeff) * (2*N)'(sample);
  assign sh   = acc >>> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (ena) begin
      if (clr) begin
        acc <= '0;
      end else if (step) begin
        acc <= acc + AW'(prod);
      end
    end
  end

  always_comb begin
    res = sh[N-1:0];
    if (sh > HI) begin
      res = HI[N-1:0];
    end else if (sh < LO) begin
      res = LO[N-1:0];
    end
  end

endmodule

// File: rtl/fir_seq_mac.sv
// Sequential FIR filter: one tap per cycle, one sample in flight,
// valid/ready on both the sample and the result side.
module fir_seq_mac
  import fir_pkg::*;
#(
  parameter int NUM_TAPS    = 8,
  parameter int NUMBER_SIZE = 16,
  parameter int SHIFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          coeff_we,
  input  logic [$clog2(NUM_TAPS)-1:0]   coeff_addr,
  input  logic signed [NUMBER_SIZE-1:0] coeff_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [NUMBER_SIZE-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [NUMBER_SIZE-1:0] out_data,
  output logic                          busy
);

  localparam int CW = $clog2(NUM_TAPS);
  localparam logic [CW-1:0] LAST = CW'(NUM_TAPS - 1);

  state_t state;
  state_t state_nx;

  logic [CW-1:0]                 cnt;
  logic signed [NUMBER_SIZE-1:0] coef [NUM_TAPS];
  logic signed [NUMBER_SIZE-1:0] dl   [NUM_TAPS];
  logic signed [NUMBER_SIZE-1:0] res;
  logic                          accept;
  logic                          wr;

  assign accept = in_valid & in_ready;
  assign wr = ena & coeff_we & (state == IDLE)
            & (int'(coeff_addr) < NUM_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (ena) begin
      unique case (state)
        IDLE: if (accept) state_nx = MAC;
        MAC:  if (cnt == LAST) state_nx = OUT;
        OUT:  if (out_valid & out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // rst_n gates in_ready so nothing is offered while reset is held
  always_comb begin
    in_ready = rst_n & ena & (state == IDLE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef[i] <= '0;
        dl[i]   <= '0;
      end
    end else if (ena) begin
      if (wr) begin
        coef[coeff_addr] <= coeff_data;
      end
      if (accept) begin
        dl[0] <= in_data;
        for (int i = 1; i < NUM_TAPS; i++) begin
          dl[i] <= dl[i-1];
        end
        cnt <= '0;
      end else if (state == MAC) begin
        cnt <= cnt + 1'b1;
      end
      // first OUT cycle registers the result; it then holds until taken
      if (state == OUT) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= res;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  fir_mac_unit #(
    .NUM_TAPS   (NUM_TAPS),
    .NUMBER_SIZE(NUMBER_SIZE),
    .SHIFT      (SHIFT)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (accept),
    .step  (state == MAC),
    .coeff (coef[cnt]),
    .sample(dl[cnt]),
    .res   (res)
  );

endmodule

// File: tb/tb_fir_seq_mac.sv
// Bench for fir_seq_mac: 4-tap instance with vector table and
// corner sequences, 8-tap SHIFT=2 instance against a model.
module tb_fir_seq_mac;

  typedef struct {
    logic [63:0] c;
    int          din;
    int          dout;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   ena = 1'b1;
  int     checks = 0;
  int     errors = 0;
  int     exp_q[$];
  int     ov_seen = 0;
  logic   watch = 1'b0;
  longint c8[8];
  longint d8[8];
  vec_t   tbl[13];

  always #5 clk = ~clk;

  fir_seq_mac_if #(.NUM_TAPS(4), .NUMBER_SIZE(16)) f4 ();
  fir_seq_mac_if #(.NUM_TAPS(8), .NUMBER_SIZE(16)) f8 ();

  fir_seq_mac #(.NUM_TAPS(4), .NUMBER_SIZE(16), .SHIFT(0)) u4 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .coeff_we(f4.coeff_we), .coeff_addr(f4.coeff_addr),
    .coeff_data(f4.coeff_data),
    .in_valid(f4.in_valid), .in_ready(f4.in_ready),
    .in_data(f4.in_data),
    .out_valid(f4.out_valid), .out_ready(f4.out_ready),
    .out_data(f4.out_data), .busy(f4.busy)
  );

  fir_seq_mac #(.NUM_TAPS(8), .NUMBER_SIZE(16), .SHIFT(2)) u8 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .coeff_we(f8.coeff_we), .coeff_addr(f8.coeff_addr),
    .coeff_data(f8.coeff_data),
    .in_valid(f8.in_valid), .in_ready(f8.in_ready),
    .in_data(f8.in_data),
    .out_valid(f8.out_valid), .out_ready(f8.out_ready),
    .out_data(f8.out_data), .busy(f8.busy)
  );

  always @(negedge clk) begin
    if (watch && f4.out_valid) ov_seen++;
  end

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wc4(input int a, input int d);
    @(negedge clk);
    f4.coeff_we   = 1'b1;
    f4.coeff_addr = 2'(a);
    f4.coeff_data = 16'(d);
    @(posedge clk);
    #1 f4.coeff_we = 1'b0;
  endtask

  task automatic setc4(input logic [63:0] c);
    for (int i = 0; i < 4; i++) wc4(i, int'(c[16*i +: 16]));
  endtask

  task automatic send4(input int din, input int exp, input string name);
    int n;
    n = 0;
    @(negedge clk);
    f4.in_valid = 1'b1;
    f4.in_data  = 16'(din);
    while (!f4.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_rdy"}, f4.in_ready, 1);
    exp_q.push_back(exp);
    @(posedge clk);
    #1 f4.in_valid = 1'b0;
  endtask

  task automatic recv4(input string name);
    int n;
    n = 0;
    f4.out_ready = 1'b1;
    @(negedge clk);
    while (!f4.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, f4.out_valid, 1);
    if (exp_q.size() != 0) chk(name, f4.out_data, exp_q.pop_front());
    @(posedge clk);
    #1 f4.out_ready = 1'b0;
  endtask

  task automatic xfer4(input int din, input int exp, input string name);
    send4(din, exp, name);
    recv4(name);
  endtask

  function automatic int model8(input int din);
    longint s;
    for (int k = 7; k > 0; k--) d8[k] = d8[k-1];
    d8[0] = din;
    s = 0;
    for (int k = 0; k < 8; k++) s += c8[k] * d8[k];
    s = s >>> 2;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic wc8(input int a, input int d);
    @(negedge clk);
    f8.coeff_we   = 1'b1;
    f8.coeff_addr = 3'(a);
    f8.coeff_data = 16'(d);
    @(posedge clk);
    #1 f8.coeff_we = 1'b0;
  endtask

  task automatic recv8(input string name);
    int n;
    n = 0;
    f8.out_ready = 1'b1;
    @(negedge clk);
    while (!f8.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, f8.out_valid, 1);
    if (exp_q.size() != 0) chk(name, f8.out_data, exp_q.pop_front());
    @(posedge clk);
    #1 f8.out_ready = 1'b0;
  endtask

  task automatic xfer8(input int din, input string name);
    int n;
    n = 0;
    @(negedge clk);
    f8.in_valid = 1'b1;
    f8.in_data  = 16'(din);
    while (!f8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_rdy"}, f8.in_ready, 1);
    exp_q.push_back(model8(din));
    @(posedge clk);
    #1 f8.in_valid = 1'b0;
    recv8(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    f4.coeff_we = 0; f4.coeff_addr = 0; f4.coeff_data = 0;
    f4.in_valid = 0; f4.in_data = 0; f4.out_ready = 0;
    f8.coeff_we = 0; f8.coeff_addr = 0; f8.coeff_data = 0;
    f8.in_valid = 0; f8.in_data = 0; f8.out_ready = 0;
    for (int k = 0; k < 8; k++) begin
      c8[k] = 0;
      d8[k] = 0;
    end

    tbl[0]  = '{64'h0004_0003_0002_0001, 1, 1};
    tbl[1]  = '{64'h0004_0003_0002_0001, 0, 2};
    tbl[2]  = '{64'h0004_0003_0002_0001, 0, 3};
    tbl[3]  = '{64'h0004_0003_0002_0001, 0, 4};
    tbl[4]  = '{64'h0004_0003_0002_0001, 0, 0};
    tbl[5]  = '{64'h7FFF_7FFF_7FFF_7FFF, 32767, 32767};
    tbl[6]  = '{64'h7FFF_7FFF_7FFF_7FFF, 32767, 32767};
    tbl[7]  = '{64'h7FFF_7FFF_7FFF_7FFF, 32767, 32767};
    tbl[8]  = '{64'h7FFF_7FFF_7FFF_7FFF, 32767, 32767};
    tbl[9]  = '{64'h7FFF_7FFF_7FFF_7FFF, -32768, 32767};
    tbl[10] = '{64'h7FFF_7FFF_7FFF_7FFF, -32768, -32768};
    tbl[11] = '{64'h7FFF_7FFF_7FFF_7FFF, -32768, -32768};
    tbl[12] = '{64'h7FFF_7FFF_7FFF_7FFF, -32768, -32768};

    // reset values, with ena high throughout
    repeat (2) @(negedge clk);
    chk("rst_out_valid", f4.out_valid, 0);
    chk("rst_out_data", f4.out_data, 0);
    chk("rst_busy", f4.busy, 0);
    chk("rst_in_ready", f4.in_ready, 0);
    chk("rst_in_ready8", f8.in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", f4.in_ready, 1);

    for (int i = 0; i < 13; i++) begin
      if (i == 0 || tbl[i].c != tbl[i-1].c) setc4(tbl[i].c);
      xfer4(tbl[i].din, tbl[i].dout, $sformatf("vec%0d", i));
    end

    // latency, 4 taps
    @(negedge clk);
    f4.in_valid = 1'b1;
    f4.in_data  = 16'sd0;
    chk("lat4_rdy", f4.in_ready, 1);
    @(posedge clk);
    #1 f4.in_valid = 1'b0;
    n = 0;
    while (!f4.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("lat4", n, 5);
    exp_q.push_back(-32768);
    recv4("lat4_data");

    // backpressure
    setc4(64'h0000_0000_0000_0001);
    @(negedge clk);
    f4.in_valid = 1'b1;
    f4.in_data  = 16'sd100;
    @(posedge clk);
    #1 f4.in_valid = 1'b0;
    n = 0;
    while (!f4.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", f4.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_v%0d", i), f4.out_valid, 1);
      chk($sformatf("bp_hold_d%0d", i), f4.out_data, 100);
      chk($sformatf("bp_rdy%0d", i), f4.in_ready, 0);
    end
    f4.out_ready = 1'b1;
    @(posedge clk);
    #1 f4.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_done_valid", f4.out_valid, 0);
    chk("bp_done_busy", f4.busy, 0);
    chk("bp_done_rdy", f4.in_ready, 1);

    // coefficient write during MAC is dropped
    @(negedge clk);
    f4.in_valid = 1'b1;
    f4.in_data  = 16'sd5;
    @(posedge clk);
    #1 f4.in_valid = 1'b0;
    exp_q.push_back(5);
    @(negedge clk);
    f4.coeff_we   = 1'b1;
    f4.coeff_addr = 2'd0;
    f4.coeff_data = 16'sd9;
    @(posedge clk);
    #1 f4.coeff_we = 1'b0;
    recv4("mac_wr");
    xfer4(7, 7, "after_mac_wr");

    // write and accept in the same IDLE cycle
    @(negedge clk);
    f4.in_valid   = 1'b1;
    f4.in_data    = 16'sd2;
    f4.coeff_we   = 1'b1;
    f4.coeff_addr = 2'd0;
    f4.coeff_data = 16'sd3;
    @(posedge clk);
    #1;
    f4.in_valid = 1'b0;
    f4.coeff_we = 1'b0;
    exp_q.push_back(6);
    recv4("same_cycle");

    // enable low freezes everything
    @(negedge clk);
    ena = 1'b0;
    #1 chk("ena_rdy", f4.in_ready, 0);
    ena = 1'b1;
    @(negedge clk);
    f4.in_valid = 1'b1;
    f4.in_data  = 16'sd4;
    @(posedge clk);
    #1 f4.in_valid = 1'b0;
    @(posedge clk);
    #1 ena = 1'b0;
    n = 1;
    repeat (3) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("ena_busy", f4.busy, 1);
    chk("ena_no_out", f4.out_valid, 0);
    ena = 1'b1;
    while (!f4.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ena_lat", n, 8);
    exp_q.push_back(12);
    recv4("ena_data");

    // reset at MAC cycle 2
    setc4(64'h0004_0003_0002_0001);
    ov_seen = 0;
    watch   = 1'b1;
    @(negedge clk);
    f4.in_valid = 1'b1;
    f4.in_data  = 16'sd1;
    @(posedge clk);
    #1 f4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", f4.out_valid, 0);
    chk("mid_rst_busy", f4.busy, 0);
    chk("mid_rst_rdy", f4.in_ready, 0);
    chk("mid_rst_data", f4.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_out", ov_seen, 0);
    watch = 1'b0;
    xfer4(1, 0, "zero_c0");
    xfer4(0, 0, "zero_c1");
    setc4(64'h0004_0003_0002_0001);
    xfer4(0, 3, "dl_cleared");

    // 8 taps: latency, then random run against the model
    @(negedge clk);
    f8.in_valid = 1'b1;
    f8.in_data  = 16'sd0;
    chk("lat8_rdy", f8.in_ready, 1);
    exp_q.push_back(model8(0));
    @(posedge clk);
    #1 f8.in_valid = 1'b0;
    n = 0;
    while (!f8.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("lat8", n, 9);
    recv8("lat8_data");

    for (int k = 0; k < 8; k++) begin
      c8[k] = longint'(int'($urandom_range(40)) - 20);
      wc8(k, int'(c8[k]));
    end
    for (int j = 0; j < 12; j++) begin
      xfer8(int'($urandom_range(65535)) - 32768, $sformatf("rnd8_%0d", j));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_seq_mac.md
FIR_SEQ_MAC -- requirements
Module: fir_seq_mac

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 8, number of filter taps (>=2).
REQ-002 SHALL have parameter NUMBER_SIZE, default 16, signed sample and coefficient width.
REQ-003 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the accumulator before output.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  global enable; when 0 all state holds.
REQ-007 SHALL have port coeff_we  input  1  coefficient write strobe.
REQ-008 SHALL have port coeff_addr  input  clog2(NUM_TAPS)  coefficient index.
REQ-009 SHALL have port coeff_data  input  NUMBER_SIZE  signed coefficient value.
REQ-010 SHALL have port in_valid  input  1  sample offered.
REQ-011 SHALL have port in_ready  output  1  block can accept a sample.
REQ-012 SHALL have port in_data  input  NUMBER_SIZE  signed sample x[n].
REQ-013 SHALL have port out_valid  output  1  y[n] available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts y[n].
REQ-015 SHALL have port out_data  output  NUMBER_SIZE  signed saturated y[n].
REQ-016 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 SHALL compute y[n] = sat((sum over k=0..NUM_TAPS-1 of c[k]*x[n-k]) >>> SHIFT), all operands signed two's complement.
REQ-018 SHALL use an accumulator of 2*NUMBER_SIZE+clog2(NUM_TAPS) bits; no intermediate overflow.
REQ-019 SHALL saturate out_data to [-2^(NUMBER_SIZE-1), 2^(NUMBER_SIZE-1)-1].
REQ-020 SHALL implement states IDLE, MAC, OUT; IDLE->MAC on in_valid&in_ready; MAC->OUT after NUM_TAPS MAC cycles; OUT->IDLE on out_ready.
REQ-021 SHALL assert in_ready only in IDLE with ena=1.
REQ-022 SHALL, on accept, shift in_data into delay line position 0, older samples move up one, oldest discarded.
REQ-023 SHALL clear the accumulator on accept and perform exactly one tap multiply-accumulate per MAC cycle, tap index 0 upward.
REQ-024 SHALL assert out_valid exactly NUM_TAPS+1 cycles after the accepting edge and hold out_valid and out_data stable until out_ready.
REQ-025 SHALL write coeff_data to c[coeff_addr] on coeff_we only in IDLE; writes in MAC or OUT are ignored.
REQ-026 SHALL give a coefficient write priority over nothing else: coeff_we and sample accept in the same IDLE cycle both take effect, the new coefficient used for that sample.
REQ-027 SHALL freeze state, counters, accumulator and outputs while ena=0.
REQ-028 SHALL ignore coeff_addr >= NUM_TAPS.

Reset
REQ-029 SHALL on rst_n=0 force state IDLE, tap counter 0, accumulator 0, delay line 0, all coefficients 0.
REQ-030 SHALL drive out_valid=0, out_data=0, busy=0 during reset; in_ready=0 during reset and 1 from the first enabled IDLE cycle after release.
REQ-031 SHALL abandon any in-progress computation on reset mid-MAC or mid-OUT, producing no output for it.

Structure
REQ-032 SHALL place the state enumeration, the accumulator-width constant function and the saturation limit constants in shared package fir_pkg.
REQ-033 SHALL instantiate one sub-module fir_mac_unit (signed multiply, accumulate, shift-and-saturate).

Verification
REQ-034 SHALL cover impulse: NUM_TAPS=4, SHIFT=0, c={1,2,3,4}, inputs 1,0,0,0,0 -> outputs 1,2,3,4,0.
REQ-035 SHALL cover positive saturation: all c=32767, inputs 32767 x4 -> out_data=32767; negative: c=32767, inputs -32768 -> out_data=-32768.
REQ-036 SHALL cover backpressure: out_ready low 5 cycles -> out_valid and out_data held, in_ready=0, then one transfer and return to IDLE.
REQ-037 SHALL cover coefficient write during MAC: c[0]=1, write c[0]=9 in MAC -> current and next result use c[0]=1.
REQ-038 SHALL cover reset at MAC cycle 2 -> out_valid never asserts, delay line and coefficients 0, next impulse yields all-zero outputs.
REQ-039 SHALL cover latency: accept at edge T -> out_valid first high after edge T+NUM_TAPS+1, for NUM_TAPS=4 and 8.
